ucode_sequencer: RTL
====================

UCODE_SEQUENCER -- requirements
Module: ucode_sequencer

Interface
REQ-001 Parameter AW, default 6: micro-address width.
REQ-002 Parameter NQ, default 5: number of branch qualifiers; legal range 1..AW.
REQ-003 Parameter CW, default 3: cond field width; 2^CW SHALL be at least NQ+1.
REQ-004 Parameter OPW, default 4: dispatch opcode width; OPW SHALL be at most AW.
REQ-005 Parameter DISPATCH_BASE, default 0: base micro-address for IRD dispatch.
REQ-006 Parameter RESET_ADDR, default 18: micro-address after reset.
REQ-007 Parameter SD, default 4: return-stack depth; legal range 1..16.
REQ-008 clk, input, 1: sole clock; all state updates on its rising edge.
REQ-009 arst_n, input, 1: reset, asynchronous, active-low.
REQ-010 en, input, 1: advance enable; 0 stalls the sequencer.
REQ-011 ird, input, 1: dispatch on opcode.
REQ-012 cond, input, CW: qualifier select; 0 means unconditional.
REQ-013 j, input, AW: jump field of the current microinstruction.
REQ-014 op, input, 2: sequencing op; 0=NEXT, 1=CALL, 2=RET, 3=NEXT.
REQ-015 qual, input, NQ: branch qualifiers, for example mem_rdy, ben, ir[11], priv and interrupt.
REQ-016 opcode, input, OPW: dispatch opcode, for example ir[15:12].
REQ-017 next_uaddr, output, AW: combinational next micro-address.
REQ-018 uaddr, output, AW: registered current micro-address, which drives the control-store address.
REQ-019 stk_depth, output, 5: number of occupied stack entries.
REQ-020 stk_ovf, output, 1: sticky flag, set on push to a full stack.
REQ-021 stk_unf, output, 1: sticky flag, set on pop from an empty stack.

Function
REQ-022 The formed address SHALL be j with qual[cond-1] ORed into bit cond-1 when 1<=cond<=NQ, and SHALL be j unmodified for cond=0 or cond>NQ.
REQ-023 Priority: ird=1 gives next_uaddr=(DISPATCH_BASE+zero-extended opcode) mod 2^AW; op, j and cond are ignored; there is no stack action.
REQ-024 With ird=0 and op=RET: non-empty stack gives next_uaddr=top entry and a pop; empty stack gives next_uaddr=RESET_ADDR and sets stk_unf at the edge.
REQ-025 With ird=0 and op=CALL: next_uaddr=formed address, and (uaddr+1) mod 2^AW is pushed.
REQ-026 A CALL with stk_depth=SD SHALL still jump, SHALL drop the push with the stack contents unchanged, and SHALL set stk_ovf at the edge.
REQ-027 With ird=0 and op=NEXT or op=3: next_uaddr=formed address; no stack action.
REQ-028 next_uaddr SHALL be purely combinational from the current inputs, uaddr and the stack top, with zero-cycle latency.
REQ-029 Rising edge with en=1: uaddr<=next_uaddr, and the push or pop commits with stk_depth updated in the same edge.
REQ-030 Rising edge with en=0: uaddr, stack, stk_depth and flags SHALL hold; the stalled op SHALL be re-evaluated on the first enabled edge.
REQ-031 The stack SHALL be strict LIFO; entries above stk_depth are don't-care.
REQ-032 stk_ovf and stk_unf SHALL clear only on reset.
REQ-033 All address arithmetic SHALL be modulo 2^AW, with no saturation.

Reset
REQ-034 arst_n=0 SHALL immediately, independent of clk, set uaddr=RESET_ADDR, stk_depth=0, stk_ovf=0 and stk_unf=0; stack contents become don't-care.
REQ-035 Reset asserted mid-CALL or mid-RET SHALL discard that operation with no partial push or pop.
REQ-036 The first enabled edge after arst_n rises SHALL sequence normally from RESET_ADDR.

Verification
All scenarios use AW=6, NQ=5, CW=3, OPW=4, DISPATCH_BASE=0, RESET_ADDR=18, SD=4.
REQ-037 Conditional branch: j=32, cond=2, qual=5'b00010 -> next_uaddr=34; with qual=5'b00000 -> 32; with cond=7 -> 32.
REQ-038 Dispatch overrides the stack: ird=1, opcode=11, op=CALL -> uaddr=11 after the edge, stk_depth unchanged.
REQ-039 Call and return: uaddr=10, CALL with j=40, cond=0 -> uaddr=40, stk_depth=1; then RET -> uaddr=11, stk_depth=0.
REQ-040 Stack limits: 5 consecutive CALLs -> stk_ovf=1 after the 5th, stk_depth=4, 5th jump still taken; then 4 RETs return the first 4 pushed addresses in reverse order; a 5th RET -> uaddr=18, stk_unf=1.
REQ-041 Stall: en=0 with op=CALL for 3 cycles -> uaddr and stk_depth unchanged; en=1 -> the CALL completes once.
REQ-042 Asynchronous reset: stk_depth=2, pulse arst_n low between clock edges -> uaddr=18, stk_depth=0 and both flags 0 before the next edge.

Source files
------------

// File: rtl/ucode_sequencer.sv
// ucode_sequencer
//   Microprogram sequencer. Each cycle it forms the next micro-address from
//   the current microinstruction's jump field, a selectable branch qualifier,
//   an opcode dispatch, or a small return-address stack. The registered
//   micro-address drives the control-store address.
//
// Ports
//   clk         in   sole clock, rising edge
//   arst_n      in   asynchronous active-low reset
//   en          in   advance enable (0 = stall, everything holds)
//   ird         in   dispatch on opcode (highest priority)
//   cond        in   CW    qualifier select, 0 = unconditional
//   j           in   AW    jump field
//   op          in   2     0/3 = NEXT, 1 = CALL, 2 = RET
//   qual        in   NQ    branch qualifiers
//   opcode      in   OPW   dispatch opcode
//   next_uaddr  out  AW    combinational next micro-address
//   uaddr       out  AW    registered current micro-address
//   stk_depth   out  5     occupied stack entries
//   stk_ovf     out  1     sticky: push attempted on a full stack
//   stk_unf     out  1     sticky: pop attempted on an empty stack
module ucode_sequencer #(
    parameter int AW            = 6,
    parameter int NQ            = 5,
    parameter int CW            = 3,
    parameter int OPW           = 4,
    parameter int DISPATCH_BASE = 0,
    parameter int RESET_ADDR    = 18,
    parameter int SD            = 4
) (
    input  logic           clk,
    input  logic           arst_n,
    input  logic           en,
    input  logic           ird,
    input  logic [CW-1:0]  cond,
    input  logic [AW-1:0]  j,
    input  logic [1:0]     op,
    input  logic [NQ-1:0]  qual,
    input  logic [OPW-1:0] opcode,
    output logic [AW-1:0]  next_uaddr,
    output logic [AW-1:0]  uaddr,
    output logic [4:0]     stk_depth,
    output logic           stk_ovf,
    output logic           stk_unf
);

    localparam logic [1:0]    OP_CALL = 2'd1;
    localparam logic [1:0]    OP_RET  = 2'd2;
    localparam logic [AW-1:0] RST_UA  = AW'(RESET_ADDR);
    localparam logic [AW-1:0] DBASE   = AW'(DISPATCH_BASE);
    localparam logic [4:0]    SD_V    = 5'(SD);

    // Qualifier select 1..NQ ORs qual[cond-1] into bit cond-1 of the jump
    // field; 0 and out-of-range selects leave the jump field untouched.
    function automatic logic [AW-1:0] form_addr(
        input logic [AW-1:0] jf,
        input logic [CW-1:0] cf,
        input logic [NQ-1:0] qf
    );
        logic [AW-1:0] a;
        a = jf;
        for (int i = 0; i < NQ; i++) begin
            if (cf == CW'(i + 1)) a[i] = jf[i] | qf[i];
        end
        return a;
    endfunction

    logic [AW-1:0] stack [SD];
    logic [AW-1:0] top;
    logic [AW-1:0] ret_addr;
    logic          full;
    logic          empty;
    logic          call_req;
    logic          ret_req;
    logic          do_push;
    logic          do_pop;

    assign full     = (stk_depth == SD_V);
    assign empty    = (stk_depth == 5'd0);
    assign call_req = !ird && (op == OP_CALL);
    assign ret_req  = !ird && (op == OP_RET);
    assign do_push  = call_req && !full;
    assign do_pop   = ret_req && !empty;
    assign ret_addr = uaddr + AW'(1);

    // Top-of-stack lookup by depth compare, so SD=1 needs no index arithmetic.
    always_comb begin
        top = '0;
        for (int i = 0; i < SD; i++) begin
            if (stk_depth == 5'(i + 1)) top = stack[i];
        end
    end

    always_comb begin
        next_uaddr = form_addr(j, cond, qual);
        if (ird) begin
            next_uaddr = DBASE + AW'(opcode);
        end else if (op == OP_RET) begin
            next_uaddr = empty ? RST_UA : top;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            uaddr     <= RST_UA;
            stk_depth <= 5'd0;
            stk_ovf   <= 1'b0;
            stk_unf   <= 1'b0;
        end else if (en) begin
            uaddr <= next_uaddr;
            if (do_push) begin
                stk_depth <= stk_depth + 5'd1;
            end else if (do_pop) begin
                stk_depth <= stk_depth - 5'd1;
            end
            if (call_req && full) stk_ovf <= 1'b1;
            if (ret_req && empty) stk_unf <= 1'b1;
        end
    end

    // Stack storage carries no reset; entries at or above stk_depth are dead.
    always_ff @(posedge clk) begin
        if (en && do_push) begin
            for (int i = 0; i < SD; i++) begin
                if (stk_depth == 5'(i)) stack[i] <= ret_addr;
            end
        end
    end

endmodule
